// File: rtl/draw_letters_pkg.sv
// draw_letters shared types and board-label geometry.
// Colours, coordinates and pipeline bundles for the label overlay.
package draw_letters_pkg;

  localparam logic [10:0] BOARD_X0   = 11'd256;
  localparam logic [10:0] BOARD_X1   = 11'd768;
  localparam logic [10:0] BOARD_Y0   = 11'd128;
  localparam logic [10:0] BOARD_Y1   = 11'd640;
  localparam logic [10:0] LBL_TOP_Y0 = 11'd104;
  localparam logic [10:0] LBL_BOT_Y0 = 11'd648;
  localparam logic [10:0] LBL_L_X0   = 11'd236;
  localparam logic [10:0] LBL_R_X0   = 11'd780;
  localparam logic [10:0] GLYPH_W    = 11'd8;
  localparam logic [10:0] GLYPH_H    = 11'd16;
  localparam logic [10:0] SQ         = 11'd64;

  // glyph placement inside its 64-pixel square
  localparam logic [10:0] GLYPH_XOFF = (SQ - GLYPH_W) >> 1;
  localparam logic [10:0] GLYPH_YOFF = (SQ - GLYPH_H) >> 1;

  localparam logic [11:0] LETTER_RGB_DEF = 12'hFFF;
  localparam logic [11:0] HL_RGB_DEF     = 12'hFC0;

  typedef enum logic {
    BLINK_OFF = 1'b0,
    BLINK_ON  = 1'b1
  } blink_e;

  typedef struct packed {
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;
  } vga_t;

  typedef struct packed {
    vga_t       vga;
    logic       file;
    logic       rank;
    logic [2:0] col;
    logic [2:0] idx;
  } lbl_t;

endpackage

// File: rtl/draw_letters_if.sv
// VGA timing/pixel stream between drawing stages.
// master drives the stream, slave consumes it.
interface vga_if;
  logic [10:0] hcount;
  logic [10:0] vcount;
  logic        hsync;
  logic        vsync;
  logic        hblnk;
  logic        vblnk;
  logic [11:0] rgb;

  modport master (
    output hcount, vcount, hsync, vsync,
    output hblnk, vblnk, rgb
  );

  modport slave (
    input hcount, vcount, hsync, vsync,
    input hblnk, vblnk, rgb
  );
endinterface

// File: rtl/draw_letters_label_blink.sv
// Frame counter and ON/OFF blink state for the label highlight.
// Toggles every BLINK_FRAMES frame ticks; resets into ON.
module label_blink
  import draw_letters_pkg::*;
#(
  parameter int BLINK_FRAMES = 30
) (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_tick,
  output logic blink_on
);

  localparam logic [7:0] LAST = 8'(BLINK_FRAMES - 1);

  blink_e     state_q, state_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  // state and frame counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= BLINK_ON;
      frame_cnt_q <= 8'd0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // advance count per frame, flip phase at the last frame
  always_comb begin
    state_d     = state_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) begin
      if (frame_cnt_q == LAST) begin
        frame_cnt_d = 8'd0;
        state_d = (state_q == BLINK_ON) ?
                  BLINK_OFF : BLINK_ON;
      end else begin
        frame_cnt_d = frame_cnt_q + 8'd1;
      end
    end
  end

  // phase output
  always_comb begin
    blink_on = (state_q == BLINK_ON);
  end

endmodule

// File: rtl/draw_letters.sv
// Overlays file A-H / rank 1-8 labels on the VGA stream.
// Two-stage pipeline; selected labels highlight with blink.
module draw_letters
  import draw_letters_pkg::*;
#(
  parameter logic [11:0] LETTER_RGB = LETTER_RGB_DEF,
  parameter logic [11:0] HL_RGB = HL_RGB_DEF,
  parameter int BLINK_FRAMES = 30,
  parameter bit BLINK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] char_pixels,
  input  logic [2:0] sel_file,
  input  logic [2:0] sel_rank,
  input  logic       sel_valid,
  vga_if.slave       vga_in,
  vga_if.master      vga_out
);

  logic [10:0] hc, vc;
  logic        hm_ok, vm_ok;
  logic        fy_ok, rl_ok, rr_ok;
  logic        in_file, in_rank;
  lbl_t        s1_d, s1_q;
  vga_t        out_d, out_q;
  logic [2:0]  bit_sel;
  logic        px, draw, hit, hl, blank;
  logic        frame_tick, blink_on;

  assign hc = vga_in.hcount;
  assign vc = vga_in.vcount;

  // stage 0: label region decode on the incoming stream
  always_comb begin
    hm_ok = ({5'd0, hc[5:0]} >= GLYPH_XOFF) &&
            ({5'd0, hc[5:0]} < GLYPH_XOFF + GLYPH_W);
    vm_ok = ({5'd0, vc[5:0]} >= GLYPH_YOFF) &&
            ({5'd0, vc[5:0]} < GLYPH_YOFF + GLYPH_H);
    fy_ok = (vc >= LBL_TOP_Y0 &&
             vc < LBL_TOP_Y0 + GLYPH_H) ||
            (vc >= LBL_BOT_Y0 &&
             vc < LBL_BOT_Y0 + GLYPH_H);
    rl_ok = hc >= LBL_L_X0 &&
            hc < LBL_L_X0 + GLYPH_W;
    rr_ok = hc >= LBL_R_X0 &&
            hc < LBL_R_X0 + GLYPH_W;
    in_file = hc >= BOARD_X0 && hc < BOARD_X1 &&
              hm_ok && fy_ok;
    in_rank = vc >= BOARD_Y0 && vc < BOARD_Y1 &&
              vm_ok && (rl_ok || rr_ok);

    s1_d.vga.hcount = vga_in.hcount;
    s1_d.vga.vcount = vga_in.vcount;
    s1_d.vga.hsync  = vga_in.hsync;
    s1_d.vga.vsync  = vga_in.vsync;
    s1_d.vga.hblnk  = vga_in.hblnk;
    s1_d.vga.vblnk  = vga_in.vblnk;
    s1_d.vga.rgb    = vga_in.rgb;
    s1_d.file = in_file;
    s1_d.rank = in_rank;
    s1_d.col  = 3'd0;
    s1_d.idx  = 3'd0;
    unique case (1'b1)
      in_file: begin
        s1_d.col = hc[2:0] - GLYPH_XOFF[2:0];
        s1_d.idx = hc[8:6] - BOARD_X0[8:6];
      end
      in_rank: begin
        s1_d.col = rl_ok ?
                   hc[2:0] - LBL_L_X0[2:0] :
                   hc[2:0] - LBL_R_X0[2:0];
        s1_d.idx = 3'd7 -
                   (vc[8:6] - BOARD_Y0[8:6]);
      end
      default: ;
    endcase
  end

  // stage 1 register, aligned with char_pixels
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) s1_q <= '0;
    else        s1_q <= s1_d;
  end

  assign frame_tick = (s1_q.vga.hcount == 11'd0) &&
                      (s1_q.vga.vcount == 11'd0);

  label_blink #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_tick (frame_tick),
    .blink_on   (blink_on)
  );

  // stage 1: glyph pixel pick and colour select
  always_comb begin
    bit_sel = 3'd7 - s1_q.col;
    px      = char_pixels[bit_sel];
    draw    = (s1_q.file | s1_q.rank) & px;
    hit     = sel_valid &
              ((s1_q.file & (s1_q.idx == sel_file)) |
               (s1_q.rank & (s1_q.idx == sel_rank)));
    hl      = hit & (blink_on | !BLINK_EN);
    blank   = s1_q.vga.hblnk | s1_q.vga.vblnk;
    out_d   = s1_q.vga;
    unique case (1'b1)
      blank | !draw:       out_d.rgb = s1_q.vga.rgb;
      !blank & draw & hl:  out_d.rgb = HL_RGB;
      !blank & draw & !hl: out_d.rgb = LETTER_RGB;
      default:             out_d.rgb = s1_q.vga.rgb;
    endcase
  end

  // stage 2 output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) out_q <= '0;
    else        out_q <= out_d;
  end

  assign vga_out.hcount = out_q.hcount;
  assign vga_out.vcount = out_q.vcount;
  assign vga_out.hsync  = out_q.hsync;
  assign vga_out.vsync  = out_q.vsync;
  assign vga_out.hblnk  = out_q.hblnk;
  assign vga_out.vblnk  = out_q.vblnk;
  assign vga_out.rgb    = out_q.rgb;

endmodule

// File: tb/tb_draw_letters.sv
// Directed bench for draw_letters.
// Hand-computed colours, latency and blink phase.
module tb_draw_letters;
  import draw_letters_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_pixels = 8'h00;
  logic [2:0] sel_file = 3'd0;
  logic [2:0] sel_rank = 3'd0;
  logic       sel_valid = 1'b0;

  vga_if vin ();
  vga_if vout ();

  draw_letters #(
    .BLINK_FRAMES (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .char_pixels (char_pixels),
    .sel_file    (sel_file),
    .sel_rank    (sel_rank),
    .sel_valid   (sel_valid),
    .vga_in      (vin),
    .vga_out     (vout)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  int ticks = 0;
  vga_t neut;
  vga_t hist [8];

  task automatic check(string tag,
                       logic [63:0] got,
                       logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic vga_t mk(int h, int v,
                              logic hs, logic vs,
                              logic hb, logic vb,
                              logic [11:0] rgb);
    vga_t r;
    r.hcount = 11'(h);
    r.vcount = 11'(v);
    r.hsync = hs;
    r.vsync = vs;
    r.hblnk = hb;
    r.vblnk = vb;
    r.rgb = rgb;
    return r;
  endfunction

  task automatic drive(vga_t v);
    vin.hcount = v.hcount;
    vin.vcount = v.vcount;
    vin.hsync = v.hsync;
    vin.vsync = v.vsync;
    vin.hblnk = v.hblnk;
    vin.vblnk = v.vblnk;
    vin.rgb = v.rgb;
  endtask

  function automatic vga_t outv();
    vga_t r;
    r.hcount = vout.hcount;
    r.vcount = vout.vcount;
    r.hsync = vout.hsync;
    r.vsync = vout.vsync;
    r.hblnk = vout.hblnk;
    r.vblnk = vout.vblnk;
    r.rgb = vout.rgb;
    return r;
  endfunction

  function automatic logic exp_blink();
    return ((ticks / 2) % 2) == 0;
  endfunction

  // assert reset between edges; registers clear at once
  task automatic do_reset();
    @(negedge clk);
    drive(neut);
    #2 rst_n = 1'b0;
    #1;
    check("rst_out", 64'(outv()), 64'd0);
    check("rst_blink", 64'(dut.u_blink.blink_on), 64'd1);
    check("rst_cnt", 64'(dut.u_blink.frame_cnt_q), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    // stage-1 holds (0,0) from reset: first edge is a tick
    ticks = 1;
  endtask

  task automatic apply(vga_t v, logic [7:0] cp,
                       string tag, logic [11:0] exp);
    @(negedge clk);
    drive(v);
    @(negedge clk);
    char_pixels = cp;
    @(negedge clk);
    check(tag, 64'(vout.rgb), 64'(exp));
  endtask

  task automatic tick();
    @(negedge clk);
    drive(mk(0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 12'h000));
    @(negedge clk);
    drive(neut);
    ticks++;
  endtask

  task automatic latency_run(string tag, int base);
    for (int i = 0; i < 8; i++)
      hist[i] = mk(base + i, 50, i[0], i[1],
                   1'b0, 1'b0, 12'h123 + 12'(i));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i >= 2)
        check(tag, 64'(outv()), 64'(hist[i-2]));
      if (i < 8) drive(hist[i]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout got 0 exp 1");
    $fatal(1);
  end

  initial begin
    vga_t a0, r8;
    neut = mk(400, 60, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0A5);
    a0 = mk(284, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h321);
    r8 = mk(243, 152, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456);
    drive(neut);
    do_reset();

    latency_run("latency", 300);

    apply(a0, 8'h80, "file_a_col0", 12'hFFF);
    apply(a0, 8'h00, "file_a_off", 12'h321);
    apply(mk(291, 655, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777),
          8'h01, "file_a_col7", 12'hFFF);
    apply(mk(291, 655, 1'b0, 1'b0, 1'b0, 1'b0, 12'h777),
          8'h80, "file_bitorder", 12'h777);

    apply(r8, 8'h01, "rank8_col7", 12'hFFF);
    sel_valid = 1'b1;
    sel_rank = 3'd7;
    sel_file = 3'd3;
    apply(r8, 8'h01, "rank8_hl", 12'hFC0);
    sel_rank = 3'd6;
    apply(r8, 8'h01, "rank8_nosel", 12'hFFF);
    apply(mk(780, 600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111),
          8'h80, "rank1_right", 12'hFFF);
    sel_rank = 3'd0;
    apply(mk(780, 600, 1'b0, 1'b0, 1'b0, 1'b0, 12'h111),
          8'h80, "rank1_hl", 12'hFC0);
    apply(a0, 8'h80, "file_nosel", 12'hFFF);
    sel_valid = 1'b0;

    apply(mk(284, 110, 1'b0, 1'b0, 1'b1, 1'b0, 12'h3C3),
          8'hFF, "hblnk_pass", 12'h3C3);
    apply(mk(243, 152, 1'b0, 1'b0, 1'b0, 1'b1, 12'h5A5),
          8'hFF, "vblnk_pass", 12'h5A5);
    apply(mk(272, 110, 1'b0, 1'b0, 1'b0, 1'b0, 12'h0F0),
          8'hFF, "gap_pass", 12'h0F0);

    do_reset();
    sel_valid = 1'b1;
    sel_file = 3'd0;
    for (int k = 0; k < 6; k++) begin
      apply(a0, 8'h80, "blink_px",
            exp_blink() ? 12'hFC0 : 12'hFFF);
      check("blink_on", 64'(dut.u_blink.blink_on),
            64'(exp_blink()));
      if (k == 2) sel_file = 3'd0;
      tick();
    end
    sel_valid = 1'b0;

    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_out", 64'(outv()), 64'd0);
    check("async_blink", 64'(dut.u_blink.blink_on), 64'd1);
    check("async_cnt", 64'(dut.u_blink.frame_cnt_q), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    ticks = 1;
    latency_run("resume", 500);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
